// File: rtl/tug_game_ctrl.sv
// Purpose : tug-of-war round sequencer (idle, arm countdown, play, win flash) driving rope position and LED control.
// Latency : outputs update on the same rising edge that samples a button/start rising edge; no extra pipeline.
// Backpressure: none; button and start inputs are level inputs consumed every cycle, held levels yield one event.
//
// Ports:
//   clk          system clock, all state changes on rising edge
//   rst          asynchronous active-high reset
//   start        debounced level; rising edge begins a round (IDLE) or ends it (WIN)
//   pb_l, pb_r   debounced player button levels
//   score[6:0]   one-hot rope position, bit 6 = left end, bit 0 = right end
//   led_control  bit1 = display enable, bit0 = game-over flag
//   winner       00 none, 01 left, 10 right
module tug_game_ctrl #(
  parameter int WAIT_CYCLES  = 50_000_000,
  parameter int FLASH_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pb_l,
  input  logic       pb_r,
  output logic [6:0] score,
  output logic [1:0] led_control,
  output logic [1:0] winner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_WIN  = 2'd3;

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  localparam logic [CW-1:0] WAIT_LOAD  = CW'(WAIT_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);

  localparam logic [6:0] CENTRE    = 7'b0001000;
  localparam logic [6:0] LEFT_END  = 7'b1000000;
  localparam logic [6:0] RIGHT_END = 7'b0000001;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [FW-1:0] flash_cnt;
  logic          flash_on;
  logic          start_q, pb_l_q, pb_r_q;
  logic          start_ev, l_ev, r_ev;
  logic          move_left, move_right;
  logic [6:0]    next_score;

  assign start_ev = start & ~start_q;
  assign l_ev     = pb_l & ~pb_l_q;
  assign r_ev     = pb_r & ~pb_r_q;

  // During ARM the directions are inverted: an early press penalises the presser.
  // Simultaneous events from both players cancel.
  always_comb begin
    move_left  = 1'b0;
    move_right = 1'b0;
    if (l_ev ^ r_ev) begin
      if (state == S_PLAY) begin
        move_left  = l_ev;
        move_right = r_ev;
      end else if (state == S_ARM) begin
        move_left  = r_ev;
        move_right = l_ev;
      end
    end
  end

  // Guards at the ends keep the rope one-hot with no wrap-around.
  always_comb begin
    next_score = score;
    if (move_left && !score[6]) begin
      next_score = score << 1;
    end else if (move_right && !score[0]) begin
      next_score = score >> 1;
    end
  end

  always_comb begin
    led_control = 2'b00;
    case (state)
      S_PLAY:  led_control = 2'b10;
      S_WIN:   led_control = {flash_on, 1'b1};
      default: led_control = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      score     <= CENTRE;
      winner    <= 2'b00;
      wait_cnt  <= '0;
      flash_cnt <= '0;
      flash_on  <= 1'b1;
      start_q   <= 1'b0;
      pb_l_q    <= 1'b0;
      pb_r_q    <= 1'b0;
    end else begin
      start_q <= start;
      pb_l_q  <= pb_l;
      pb_r_q  <= pb_r;
      case (state)
        S_IDLE: begin
          if (start_ev) begin
            state    <= S_ARM;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_ARM, S_PLAY: begin
          score <= next_score;
          if (next_score == LEFT_END || next_score == RIGHT_END) begin
            state     <= S_WIN;
            winner    <= (next_score == LEFT_END) ? 2'b01 : 2'b10;
            wait_cnt  <= '0;
            flash_cnt <= '0;
            flash_on  <= 1'b1;
          end else if (state == S_ARM) begin
            // Countdown holds at zero for one cycle, then play begins.
            if (wait_cnt == '0) begin
              state <= S_PLAY;
            end else begin
              wait_cnt <= wait_cnt - CW'(1);
            end
          end
        end
        default: begin // S_WIN
          if (start_ev) begin
            state     <= S_IDLE;
            score     <= CENTRE;
            winner    <= 2'b00;
            flash_cnt <= '0;
            flash_on  <= 1'b1;
          end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            flash_on  <= ~flash_on;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_game_ctrl.sv
module tb_tug_game_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pb_l;
  logic       pb_r;
  logic [6:0] score;
  logic [1:0] led_control;
  logic [1:0] winner;

  int n_tests;
  int n_fail;

  tug_game_ctrl #(
    .WAIT_CYCLES (4),
    .FLASH_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pb_l       (pb_l),
    .pb_r       (pb_r),
    .score      (score),
    .led_control(led_control),
    .winner     (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_l();
    pb_l = 1'b1; step(); pb_l = 1'b0;
  endtask

  task automatic pulse_r();
    pb_r = 1'b1; step(); pb_r = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    logic [1:0] flash_exp [6];
    flash_exp = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; pb_l = 1'b0; pb_r = 1'b0;
    #12;
    chk("rst_score", score, 7'b0001000);
    chk("rst_led", led_control, 2'b00);
    chk("rst_winner", winner, 2'b00);
    step();
    rst = 1'b0;
    step(); step();
    chk("idle_led", led_control, 2'b00);

    // Start: four cycles dark in ARM, then PLAY.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("arm_led", led_control, 2'b00);
      chk("arm_score", score, 7'b0001000);
      step();
    end
    chk("play_led", led_control, 2'b10);
    chk("play_score", score, 7'b0001000);

    // Left player pulls to the left end.
    pulse_l();
    chk("l1_score", score, 7'b0010000);
    step(); step();
    pulse_l();
    chk("l2_score", score, 7'b0100000);
    chk("l2_winner", winner, 2'b00);
    step(); step();
    pulse_l();
    chk("l3_score", score, 7'b1000000);
    chk("l3_winner", winner, 2'b01);
    chk("l3_led", led_control, 2'b11);

    // Blink: 11 for 3 cycles, 01 for 3, then 11; a button press is ignored.
    pb_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      pb_r = 1'b0;
      chk("flash_led", led_control, flash_exp[i]);
    end
    chk("win_hold_score", score, 7'b1000000);
    chk("win_hold_winner", winner, 2'b01);

    // Start in WIN returns to IDLE.
    pulse_start();
    chk("end_score", score, 7'b0001000);
    chk("end_winner", winner, 2'b00);
    chk("end_led", led_control, 2'b00);
    pulse_l();
    step();
    chk("idle_l_score", score, 7'b0001000);
    chk("idle_l_led", led_control, 2'b00);

    // New round with a false start by the right player.
    pulse_start();
    pulse_r();
    chk("fs_score", score, 7'b0010000);
    chk("fs_led", led_control, 2'b00);
    step();
    chk("fs_led2", led_control, 2'b00);
    step();
    chk("fs_led3", led_control, 2'b00);
    step();
    chk("fs_play_led", led_control, 2'b10);
    chk("fs_play_score", score, 7'b0010000);

    // Back to centre, then simultaneous presses cancel.
    pulse_r();
    chk("r_centre", score, 7'b0001000);
    step();
    pb_l = 1'b1; pb_r = 1'b1;
    step();
    chk("both_score", score, 7'b0001000);
    pb_l = 1'b0; pb_r = 1'b0;
    step();

    // Holding pb_r gives exactly one move.
    pb_r = 1'b1;
    step();
    chk("hold_first", score, 7'b0000100);
    for (int i = 0; i < 9; i++) step();
    chk("hold_score", score, 7'b0000100);
    pb_r = 1'b0;
    step();
    pulse_r();
    chk("r_score", score, 7'b0000010);
    chk("r_led", led_control, 2'b10);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_score", score, 7'b0001000);
    chk("arst_led", led_control, 2'b00);
    chk("arst_winner", winner, 2'b00);
    step();
    rst = 1'b0;
    step();

    // Fresh round: right player wins.
    pulse_start();
    chk("re_arm_led", led_control, 2'b00);
    chk("re_arm_score", score, 7'b0001000);
    step(); step(); step();
    chk("re_arm_led3", led_control, 2'b00);
    step();
    chk("re_play_led", led_control, 2'b10);
    pulse_r(); step();
    pulse_r(); step();
    chk("rw_score2", score, 7'b0000010);
    pulse_r();
    chk("rw_score", score, 7'b0000001);
    chk("rw_winner", winner, 2'b10);
    chk("rw_led", led_control, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
